// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: control FSM, A/Q/q_1 shift registers, shared add/sub stage driver.
// Optional feature: define BOOTH_OPCNT_EN to add the op_count output (add/sub operations per multiply).
module booth_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   mcand,
    input  logic signed [WIDTH-1:0]   mplier,
    output logic signed [WIDTH-1:0]   as_in1,
    output logic signed [WIDTH-1:0]   as_in2,
    output logic                      as_oper,
    input  logic signed [WIDTH-1:0]   as_out,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
`ifdef BOOTH_OPCNT_EN
    ,
    output logic [CNT_W-1:0]          op_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [WIDTH-1:0]   r_a;
    logic signed [WIDTH-1:0]   r_m;
    logic signed [WIDTH-1:0]   r_q;
    logic                      r_q1;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_done;
    logic signed [2*WIDTH-1:0] r_product;

    logic [1:0]                w_pair;
    logic                      w_addsub;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_sgn;
    logic signed [WIDTH-1:0]   w_a_mid;
    logic signed [WIDTH-1:0]   w_a_shift;
    logic signed [WIDTH-1:0]   w_q_shift;

    // Sign to shift into A. The add/sub result msb is wrong when it overflowed,
    // so flip it in that case; with no add/sub the A msb is replicated.
    function automatic logic booth_sign(input logic a_msb, input logic m_msb,
                                        input logic oper, input logic out_msb,
                                        input logic active);
        logic ovf;
        ovf = (a_msb == (m_msb ^ oper)) && (out_msb != a_msb);
        return active ? (out_msb ^ ovf) : a_msb;
    endfunction

    assign w_pair    = {r_q[0], r_q1};
    assign w_addsub  = w_pair[1] ^ w_pair[0];
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_cnt == CNT_W'(1));
    assign w_a_mid   = w_addsub ? as_out : r_a;
    assign w_sgn     = booth_sign(r_a[WIDTH-1], r_m[WIDTH-1], as_oper, as_out[WIDTH-1], w_addsub);
    assign w_a_shift = {w_sgn, w_a_mid[WIDTH-1:1]};
    assign w_q_shift = {w_a_mid[0], r_q[WIDTH-1:1]};

    assign as_in1  = r_a;
    assign as_in2  = r_m;
    assign as_oper = (w_pair == 2'b10);
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign product = r_product;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_RUN) && w_last;
            if (w_accept) begin
                r_m   <= mcand;
                r_q   <= mplier;
                r_a   <= '0;
                r_q1  <= 1'b0;
                r_cnt <= CNT_W'(WIDTH);
            end else if (r_state == S_RUN) begin
                r_a   <= w_a_shift;
                r_q   <= w_q_shift;
                r_q1  <= r_q[0];
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) r_product <= {w_a_shift, w_q_shift};
            end
        end
    end

`ifdef BOOTH_OPCNT_EN
    logic [CNT_W-1:0] r_opc_acc;
    logic [CNT_W-1:0] r_opc;

    // The final iteration's operation is folded in directly at the DONE entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opc_acc <= '0;
            r_opc     <= '0;
        end else begin
            if (w_accept) begin
                r_opc_acc <= '0;
            end else if ((r_state == S_RUN) && w_addsub) begin
                r_opc_acc <= r_opc_acc + CNT_W'(1);
            end
            if ((r_state == S_RUN) && w_last) r_opc <= r_opc_acc + CNT_W'(w_addsub);
        end
    end

    assign op_count = r_opc;
`endif

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl; models the add/sub stage and predicts products with plain multiplication.
module tb_booth_seq_ctrl;

    localparam int W  = 16;
    localparam int CW = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic signed [W-1:0]   mcand;
    logic signed [W-1:0]   mplier;
    logic signed [W-1:0]   as_in1;
    logic signed [W-1:0]   as_in2;
    logic                  as_oper;
    logic signed [W-1:0]   as_out;
    logic                  busy;
    logic                  done;
    logic signed [2*W-1:0] product;
`ifdef BOOTH_OPCNT_EN
    logic [CW-1:0]         op_count;
`endif

    always #5 clk = ~clk;

    assign as_out = as_oper ? (as_in1 - as_in2) : (as_in1 + as_in2);

    booth_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .as_in1  (as_in1),
        .as_in2  (as_in2),
        .as_oper (as_oper),
        .as_out  (as_out),
        .busy    (busy),
        .done    (done),
        .product (product)
`ifdef BOOTH_OPCNT_EN
        ,
        .op_count(op_count)
`endif
    );

    typedef struct {
        logic signed [2*W-1:0] prod;
        int                    opc;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   ndone   = 0;
    int   naccept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Product by ordinary multiplication; op count = number of bit transitions in {mplier,0}.
    function automatic exp_t model(input logic signed [W-1:0] mc, input logic signed [W-1:0] mp);
        exp_t   e;
        longint p;
        logic   prev;
        p = longint'(mc) * longint'(mp);
        e.prod = p[2*W-1:0];
        e.opc = 0;
        for (int i = 0; i < W; i++) begin
            prev = (i == 0) ? 1'b0 : mp[i-1];
            if (mp[i] != prev) e.opc++;
        end
        return e;
    endfunction

    function automatic logic signed [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'sh8000;
            1:       return 16'sh7FFF;
            2:       return 16'shFFFF;
            3:       return 16'sh0000;
            default: return 16'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got product %h expected no result", product);
            end else begin
                e = sb.pop_front();
                check("product", product, e.prod);
`ifdef BOOTH_OPCNT_EN
                check("op_count", 32'(op_count), e.opc);
`endif
            end
        end
    end

    // Called one time unit after a rising edge with the DUT idle.
    task automatic mul(input logic signed [W-1:0] mc, input logic signed [W-1:0] mp, input bit poke);
        exp_t e;
        int   busy_n;
        int   done_at;
        e = model(mc, mp);
        start = 1'b1; mcand = mc; mplier = mp;
        sb.push_back(e); naccept++;
        @(posedge clk); #1;
        start = 1'b0; mcand = 16'($urandom); mplier = 16'($urandom);
        busy_n = 0; done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            busy_n++;
            if (done && done_at < 0) done_at = k;
            if (poke && k == 5) begin
                start = 1'b1; mcand = 16'($urandom); mplier = 16'($urandom);
            end else if (poke && k == W) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("latency", done_at, W);
        check("busy_cycles", busy_n, W + 1);
        check("product_hold", product, e.prod);
        check("idle_oper", 32'(as_oper), 32'(e.prod[0] & ~mp[W-1]));
        if (poke) begin
            @(posedge clk); #1;
            check("ignored_start", 32'(busy), 0);
        end
    endtask

    task automatic held(input logic signed [W-1:0] mc, input logic signed [W-1:0] mp);
        exp_t e;
        int   d[$];
        e = model(mc, mp);
        start = 1'b1; mcand = mc; mplier = mp;
        sb.push_back(e); sb.push_back(e); naccept += 2;
        @(posedge clk); #1;
        for (int k = 0; k < 60; k++) begin
            if (done) d.push_back(k);
            if (k == W + 2) start = 1'b0;
            if (d.size() == 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("held_first_done", (d.size() > 0) ? d[0] : -1, W);
        check("held_second_done", (d.size() > 1) ? d[1] : -1, 2 * W + 2);
        for (int k = 0; k < 30; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check("held_idle", 32'(busy), 0);
    endtask

    task automatic reset_mid(input logic signed [W-1:0] mc, input logic signed [W-1:0] mp);
        start = 1'b1; mcand = mc; mplier = mp;
        sb.push_back(model(mc, mp)); naccept++;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_product", product, 0);
        sb.delete(); naccept--;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_product", product, 0);
        check("reset_oper", 32'(as_oper), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mul(16'sd3, 16'sd5, 1'b0);
        check("p_3x5", product, 32'd15);
        mul(-16'sd7, 16'sd6, 1'b0);
        check("p_m7x6", product, 32'hFFFF_FFD6);
        mul(16'sh8000, 16'sh8000, 1'b0);
        check("p_min_min", product, 32'h4000_0000);
        mul(16'sh8000, 16'sh7FFF, 1'b0);
        check("p_min_max", product, 32'hC000_8000);
        mul(16'sd11, -16'sd13, 1'b1);
        check("p_poked", product, 32'hFFFF_FF71);

        held(16'sd100, -16'sd200);
        check("p_held", product, 32'hFFFF_B1E0);

        reset_mid(16'sd1000, 16'sd999);
        mul(16'sd2, -16'sd3, 1'b0);
        check("p_after_rst", product, 32'hFFFF_FFFA);

`ifdef BOOTH_OPCNT_EN
        mul(16'sd1234, 16'sh5555, 1'b0);
        check("opc_5555", 32'(op_count), 16);
        mul(16'sd77, 16'shFFFF, 1'b0);
        check("opc_ffff", 32'(op_count), 1);
        mul(16'sd77, 16'sh0000, 1'b0);
        check("opc_zero", 32'(op_count), 0);
        check("p_zero", product, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic signed [W-1:0] a;
            logic signed [W-1:0] b;
            a = pick();
            b = pick();
            mul(a, b, ($urandom_range(0, 3) == 0));
        end

        @(posedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);
        check("done_count", ndone, naccept);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
